// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: single-outstanding req/ready data bus, byte-lane
// alignment, load extension and M-stage stall. Optional bus timeout via MEM_TIMEOUT_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; decode M-stage op, launch or flag fault
// REQ   | dmem_req held with stable address/enables until dmem_ready
// DONE  | one-cycle completion; pipeline advances, exc/err pulses here
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALU_outM,
    input  logic [31:0] WriteDataM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ReadDataM,
    output logic        stallM,
    output logic        mem_exc,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        dmem_req_q;
    logic        dmem_we_q;
    logic [31:0] dmem_addr_q;
    logic [3:0]  dmem_be_q;
    logic [31:0] dmem_wdata_q;
    logic [31:0] rdata_q;
    logic        mem_exc_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        op;
    logic        fault;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_d;

    always_comb begin
        op = MemWriteM | (ResultSrcM == 2'b01);

        case (funct3M)
            3'b000, 3'b100: fault = 1'b0;
            3'b001, 3'b101: fault = ALU_outM[0];
            3'b010:         fault = (ALU_outM[1:0] != 2'b00);
            default:        fault = 1'b1;
        endcase
        // Unsigned variants have no meaning for stores.
        if (MemWriteM && funct3M[2])
            fault = 1'b1;

        case (funct3M[1:0])
            2'b00:   be_d = 4'b0001 << ALU_outM[1:0];
            2'b01:   be_d = ALU_outM[1] ? 4'b1100 : 4'b0011;
            default: be_d = 4'b1111;
        endcase

        case (funct3M[1:0])
            2'b00:   wdata_d = {4{WriteDataM[7:0]}};
            2'b01:   wdata_d = {2{WriteDataM[15:0]}};
            default: wdata_d = WriteDataM;
        endcase

        case (off_q)
            2'b00:   byte_sel = dmem_rdata[7:0];
            2'b01:   byte_sel = dmem_rdata[15:8];
            2'b10:   byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (f3_q)
            3'b000:  load_d = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_d = {24'd0, byte_sel};
            3'b001:  load_d = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_d = {16'd0, half_sel};
            default: load_d = dmem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_be_q    <= 4'd0;
            dmem_wdata_q <= 32'd0;
            rdata_q      <= 32'd0;
            mem_exc_q    <= 1'b0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= '0;
            bus_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (op && fault) begin
                        state_q   <= DONE;
                        mem_exc_q <= 1'b1;
                        rdata_q   <= 32'd0;
                    end else if (op) begin
                        state_q      <= REQ;
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= MemWriteM;
                        dmem_addr_q  <= {ALU_outM[31:2], 2'b00};
                        dmem_be_q    <= be_d;
                        dmem_wdata_q <= wdata_d;
                        f3_q         <= funct3M;
                        off_q        <= ALU_outM[1:0];
`ifdef MEM_TIMEOUT_EN
                        cnt_q        <= '0;
`endif
                    end
                end
                REQ: begin
                    if (dmem_ready) begin
                        state_q    <= DONE;
                        dmem_req_q <= 1'b0;
                        if (!dmem_we_q)
                            rdata_q <= load_d;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        state_q    <= DONE;
                        dmem_req_q <= 1'b0;
                        bus_err_q  <= 1'b1;
                        rdata_q    <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_q   <= IDLE;
                    mem_exc_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                    bus_err_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall holds the instruction in M until DONE, so it cannot re-trigger.
    assign stallM     = ((state_q == IDLE) && op) || (state_q == REQ);
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
    assign ReadDataM  = rdata_q;
    assign mem_exc    = mem_exc_q;
`ifdef MEM_TIMEOUT_EN
    assign bus_err    = bus_err_q;
`else
    assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: loads, stores, faults, reset abort
// and bus wait/timeout behaviour with hand-computed expectations.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic [31:0] ALU_outM;
    logic [31:0] WriteDataM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] ReadDataM;
    logic        stallM;
    logic        mem_exc;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    // Results captured by do_access
    int          stall_n, req_n;
    logic [3:0]  be_s;
    logic        we_s, exc_s, berr_s, exc_after, berr_after, done_ok;
    logic [31:0] addr_s, wdata_s, rdm_s;

    mem_access_unit #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .ALU_outM(ALU_outM), .WriteDataM(WriteDataM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .funct3M(funct3M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .ReadDataM(ReadDataM), .stallM(stallM), .mem_exc(mem_exc), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one M-stage instruction and plays the bus; ready is given in the
    // REQ cycle with index nwait (0 = first REQ cycle). Ends one cycle after DONE.
    task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] rs,
                             input logic mw, input logic [2:0] f3, input int nwait,
                             input logic [31:0] rd);
        stall_n = 0; req_n = 0; be_s = 4'd0; we_s = 1'b0; addr_s = 32'd0; wdata_s = 32'd0;
        exc_s = 1'b0; berr_s = 1'b0; rdm_s = 32'd0; done_ok = 1'b0;
        @(negedge clk);
        ALU_outM = a; WriteDataM = wd; ResultSrcM = rs; MemWriteM = mw; funct3M = f3;
        dmem_ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (!stallM) begin
                done_ok = 1'b1;
                exc_s = mem_exc; berr_s = bus_err; rdm_s = ReadDataM;
                break;
            end
            stall_n++;
            if (dmem_req) begin
                be_s = dmem_be; we_s = dmem_we; addr_s = dmem_addr; wdata_s = dmem_wdata;
                dmem_ready = (req_n == nwait);
                dmem_rdata = rd;
                req_n++;
            end else begin
                dmem_ready = 1'b0;
            end
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        @(negedge clk);
        MemWriteM = 1'b0; ResultSrcM = 2'b00;
        #1;
        exc_after = mem_exc; berr_after = bus_err;
        checks++;
        if (!done_ok) begin
            errors++;
            $display("FAIL access_completes addr=%h: no DONE within budget (stall_n=%0d)", a, stall_n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
        ALU_outM = 32'd0; WriteDataM = 32'd0; ResultSrcM = 2'b00; MemWriteM = 1'b0; funct3M = 3'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_be, stallM, mem_exc, bus_err} !== 8'd0 ||
            dmem_addr !== 32'd0 || dmem_wdata !== 32'd0 || ReadDataM !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: req=%b we=%b be=%b addr=%h wdata=%h rd=%h exc=%b berr=%b, required all 0",
                     dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, ReadDataM, mem_exc, bus_err);
        end
        reset = 1'b1;
    endtask

    task automatic test_loads();
        // LB 0x1003, 0-wait
        do_access(32'h1003, 32'd0, 2'b01, 1'b0, 3'b000, 0, 32'h80FF_1234);
        checks++; if (be_s !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b want 1000", be_s); end
        checks++; if (addr_s !== 32'h1000) begin errors++; $display("FAIL lb_addr: got %h want 00001000", addr_s); end
        checks++; if (we_s !== 1'b0) begin errors++; $display("FAIL lb_we: got %b want 0", we_s); end
        checks++; if (rdm_s !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", rdm_s); end
        checks++; if (stall_n !== 2) begin errors++; $display("FAIL lb_stall: got %0d want 2", stall_n); end
        // LHU 0x2002, 3 wait cycles
        do_access(32'h2002, 32'd0, 2'b01, 1'b0, 3'b101, 3, 32'h9ABC_0000);
        checks++; if (be_s !== 4'b1100) begin errors++; $display("FAIL lhu_be: got %b want 1100", be_s); end
        checks++; if (rdm_s !== 32'h0000_9ABC) begin errors++; $display("FAIL lhu_data: got %h want 00009abc", rdm_s); end
        checks++; if (stall_n !== 5) begin errors++; $display("FAIL lhu_stall: got %0d want 5", stall_n); end
        checks++; if (req_n !== 4) begin errors++; $display("FAIL lhu_req_cycles: got %0d want 4", req_n); end
        // LH 0x6000 sign-extended
        do_access(32'h6000, 32'd0, 2'b01, 1'b0, 3'b001, 0, 32'h1234_8001);
        checks++; if (be_s !== 4'b0011) begin errors++; $display("FAIL lh_be: got %b want 0011", be_s); end
        checks++; if (rdm_s !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data: got %h want ffff8001", rdm_s); end
        // LBU 0x8002
        do_access(32'h8002, 32'd0, 2'b01, 1'b0, 3'b100, 1, 32'h00C3_0000);
        checks++; if (be_s !== 4'b0100) begin errors++; $display("FAIL lbu_be: got %b want 0100", be_s); end
        checks++; if (rdm_s !== 32'h0000_00C3) begin errors++; $display("FAIL lbu_data: got %h want 000000c3", rdm_s); end
        // LW 0x9000
        do_access(32'h9000, 32'd0, 2'b01, 1'b0, 3'b010, 0, 32'hCAFE_F00D);
        checks++; if (be_s !== 4'b1111) begin errors++; $display("FAIL lw_be: got %b want 1111", be_s); end
        checks++; if (rdm_s !== 32'hCAFE_F00D) begin errors++; $display("FAIL lw_data: got %h want cafef00d", rdm_s); end
    endtask

    task automatic test_stores();
        // SH 0x3002
        do_access(32'h3002, 32'hDEAD_BEEF, 2'b00, 1'b1, 3'b001, 0, 32'h1111_1111);
        checks++; if (we_s !== 1'b1) begin errors++; $display("FAIL sh_we: got %b want 1", we_s); end
        checks++; if (be_s !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", be_s); end
        checks++; if (wdata_s !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata: got %h want beefbeef", wdata_s); end
        checks++; if (addr_s !== 32'h3000) begin errors++; $display("FAIL sh_addr: got %h want 00003000", addr_s); end
        checks++; if (rdm_s !== 32'hCAFE_F00D) begin errors++; $display("FAIL sh_rd_hold: got %h want cafef00d", rdm_s); end
        // SB 0x7001
        do_access(32'h7001, 32'h0000_00A5, 2'b00, 1'b1, 3'b000, 2, 32'd0);
        checks++; if (be_s !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b want 0010", be_s); end
        checks++; if (wdata_s !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h want a5a5a5a5", wdata_s); end
        // Load and store both flagged: treated as store
        do_access(32'hA000, 32'h1122_3344, 2'b01, 1'b1, 3'b010, 0, 32'h5555_5555);
        checks++; if (we_s !== 1'b1 || wdata_s !== 32'h1122_3344) begin
            errors++; $display("FAIL both_store: we=%b wdata=%h want 1 11223344", we_s, wdata_s); end
        checks++; if (rdm_s !== 32'hCAFE_F00D) begin errors++; $display("FAIL both_rd_hold: got %h want cafef00d", rdm_s); end
    endtask

    task automatic test_faults();
        do_access(32'h4001, 32'd0, 2'b01, 1'b0, 3'b010, 0, 32'hFFFF_FFFF);
        checks++; if (req_n !== 0) begin errors++; $display("FAIL lw_mis_req: got %0d req cycles want 0", req_n); end
        checks++; if (exc_s !== 1'b1) begin errors++; $display("FAIL lw_mis_exc: got %b want 1", exc_s); end
        checks++; if (exc_after !== 1'b0) begin errors++; $display("FAIL lw_mis_exc_pulse: got %b after DONE want 0", exc_after); end
        checks++; if (rdm_s !== 32'd0) begin errors++; $display("FAIL lw_mis_rd: got %h want 0", rdm_s); end
        checks++; if (stall_n !== 1) begin errors++; $display("FAIL lw_mis_stall: got %0d want 1", stall_n); end
        do_access(32'h5000, 32'h0000_0077, 2'b00, 1'b1, 3'b100, 0, 32'd0);
        checks++; if (exc_s !== 1'b1 || req_n !== 0) begin
            errors++; $display("FAIL sb_f3_100: exc=%b req cycles=%0d want 1 0", exc_s, req_n); end
        do_access(32'h5004, 32'd0, 2'b01, 1'b0, 3'b011, 0, 32'd0);
        checks++; if (exc_s !== 1'b1 || req_n !== 0) begin
            errors++; $display("FAIL ld_f3_011: exc=%b req cycles=%0d want 1 0", exc_s, req_n); end
    endtask

    task automatic test_reset_mid_req();
        do_access(32'h9000, 32'd0, 2'b01, 1'b0, 3'b010, 0, 32'h0000_0123);
        @(negedge clk);
        ALU_outM = 32'hB004; WriteDataM = 32'h55AA_55AA; ResultSrcM = 2'b00; MemWriteM = 1'b1; funct3M = 3'b010;
        dmem_ready = 1'b0;
        @(negedge clk);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", dmem_req); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_be, mem_exc, bus_err} !== 7'd0 || dmem_addr !== 32'd0 ||
            dmem_wdata !== 32'd0 || ReadDataM !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_req: req=%b we=%b be=%b addr=%h wdata=%h rd=%h, required all 0",
                     dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, ReadDataM);
        end
        MemWriteM = 1'b0;
        #1;
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stallM); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_no_resume: req=%b want 0", dmem_req); end
        do_access(32'hC000, 32'd0, 2'b01, 1'b0, 3'b000, 0, 32'h0000_007F);
        checks++; if (rdm_s !== 32'h0000_007F || stall_n !== 2) begin
            errors++; $display("FAIL rst_next_access: rd=%h stall=%0d want 0000007f 2", rdm_s, stall_n); end
    endtask

    task automatic test_wait_timeout();
`ifdef MEM_TIMEOUT_EN
        do_access(32'hD000, 32'd0, 2'b01, 1'b0, 3'b010, 1000, 32'hFFFF_FFFF);
        checks++; if (req_n !== 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", req_n); end
        checks++; if (berr_s !== 1'b1) begin errors++; $display("FAIL to_bus_err: got %b want 1", berr_s); end
        checks++; if (berr_after !== 1'b0) begin errors++; $display("FAIL to_bus_err_pulse: got %b want 0", berr_after); end
        checks++; if (rdm_s !== 32'd0) begin errors++; $display("FAIL to_rd: got %h want 0", rdm_s); end
        do_access(32'hD000, 32'd0, 2'b01, 1'b0, 3'b010, 3, 32'h0BAD_F00D);
        checks++; if (berr_s !== 1'b0 || req_n !== 4) begin
            errors++; $display("FAIL to_ready_wins: berr=%b req cycles=%0d want 0 4", berr_s, req_n); end
        checks++; if (rdm_s !== 32'h0BAD_F00D) begin errors++; $display("FAIL to_ready_data: got %h want 0badf00d", rdm_s); end
`else
        do_access(32'hD000, 32'd0, 2'b01, 1'b0, 3'b010, 20, 32'h0BAD_F00D);
        checks++; if (req_n !== 21) begin errors++; $display("FAIL long_wait_req: got %0d want 21", req_n); end
        checks++; if (berr_s !== 1'b0) begin errors++; $display("FAIL long_wait_berr: got %b want 0", berr_s); end
        checks++; if (rdm_s !== 32'h0BAD_F00D) begin errors++; $display("FAIL long_wait_data: got %h want 0badf00d", rdm_s); end
`endif
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_reset_mid_req();
        test_wait_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit of the 5-stage RISC-V core.
- Consumes the M-stage control and data outputs of the execute-to-memory pipeline register: address, store data, ResultSrc, MemWrite and funct3.
- Drives a single-outstanding req/ready data-memory bus.
- Produces aligned, sign/zero-extended load data for the writeback path, plus a stall to freeze upstream stages while a bus access is in flight.

Parameters:
- TIMEOUT, 255: max cycles spent in REQ waiting for dmem_ready; 1..65535. Used only with MEM_TIMEOUT_EN.
- CNT_W, 16: width of the timeout counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- ALU_outM  in  32  effective byte address
- WriteDataM  in  32  store data, right-justified
- ResultSrcM  in  2  2'b01 = load in M stage
- MemWriteM  in  1  store in M stage
- funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- dmem_req  out  1  bus request, held until ready
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {ALU_outM[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  bus completion; rdata valid same cycle for reads
- dmem_rdata  in  32  read word
- ReadDataM  out  32  extended load result
- stallM  out  1  freeze F/D/E stages and E->M register
- mem_exc  out  1  one-cycle pulse: misaligned or illegal-funct3 access
- bus_err  out  1  one-cycle pulse: timeout

Behaviour:
- Operation detect: op = MemWriteM | (ResultSrcM==2'b01). If both are set, the access is a store.
- Fault condition (fault):
  - funct3 is 011, 110 or 111; or
  - H/HU with addr[0]=1; or
  - W with addr[1:0]!=0.
  - For stores, 100 and 101 are illegal.
- State machine, 3 states:
  - IDLE: if op & ~fault → REQ. If op & fault → DONE with fault flag. Otherwise stay.
  - REQ: dmem_req=1. Address, we, be and wdata are registered on IDLE exit and held stable. On dmem_ready=1 → DONE. A load captures rdata that cycle.
  - DONE: dmem_req=0. mem_exc or bus_err pulses if flagged. → IDLE unconditionally.
- stallM:
  - Combinational: 1 in IDLE when op=1.
  - 1 in REQ.
  - 0 in DONE.
  - The pipeline therefore advances exactly once per access.
  - The instruction stays in M until DONE, so no re-trigger occurs.
- Latency: a 0-wait bus (ready in first REQ cycle) gives 3 cycles of occupancy: IDLE, REQ, DONE. Each wait cycle adds 1.
- Byte enables:
  - B: 1<<addr[1:0].
  - H: addr[1] ? 1100 : 0011.
  - W: 1111.
  - Loads use the same enables.
- Store data:
  - B: byte replicated ×4.
  - H: halfword replicated ×2.
  - W: as-is.
- Load extraction: select byte/halfword by addr[1:0]. Sign-extend for B/H, zero-extend for BU/HU, word as-is.
- ReadDataM is registered. It updates only on load completion and holds otherwise. On fault or timeout it is set to 0.
- Faults never assert dmem_req; no write occurs.
- dmem_ready outside REQ is ignored.
- Reset (any state, including mid-REQ), asynchronous:
  - State → IDLE.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata → 0.
  - ReadDataM → 0.
  - mem_exc, bus_err → 0.
  - Timeout counter → 0.
  - The aborted access is not resumed.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Counter clears on REQ entry and increments each REQ cycle without ready.
  - When the count reaches TIMEOUT-1 without ready, go to DONE with bus_err flagged; dmem_req drops in DONE.
  - Ready arriving in the same cycle wins: normal completion, no error.
- MEM_TIMEOUT_EN undefined:
  - No counter logic.
  - REQ waits indefinitely.
  - bus_err tied to 0.

Test Plan:
- LB at 0x1003, rdata=0x80FF_1234 (ready in first REQ cycle) → be=1000, ReadDataM=0xFFFF_FF80, stallM high 2 cycles then low in DONE.
- LHU at 0x2002, rdata=0x9ABC_0000 after 3 wait cycles → be=1100, ReadDataM=0x0000_9ABC, stallM high 5 cycles.
- SH at 0x3002, WriteDataM=0xDEAD_BEEF → dmem_we=1, be=1100, wdata=0xBEEF_BEEF, addr=0x3000, no change to ReadDataM.
- LW at 0x4001 → no dmem_req, mem_exc pulses 1 cycle in DONE, ReadDataM=0. Also SB with funct3=100 → mem_exc.
- reset pulled low during REQ with ready withheld → dmem_req=0 immediately, state IDLE, all outputs 0. Next access after release completes normally.
- MEM_TIMEOUT_EN, TIMEOUT=4, ready never asserted → bus_err pulses after 4 REQ cycles, ReadDataM=0. Ready on the 4th cycle → normal completion, no bus_err.
